// File: rtl/pc_sequencer.sv
// pc_sequencer
// Purpose: holds the fetch program counter and selects the next one each cycle.
//   The candidates are the exception vector, the saved exception return PC,
//   a RET target, a branch/jump target, the current PC held for a stall, and
//   the sequential increment. A three-state FSM (RUN, EXC, HALT) tracks
//   exception handling and the halted condition.
// Ports:
//   clk       in   single clock; all state updates on its rising edge
//   rst       in   synchronous active-high reset
//   stall     in   hold the PC (fetch bubble)
//   br_taken  in   resolved conditional branch taken
//   jmp       in   unconditional jump
//   brj_dest  in   branch/jump target
//   ret       in   RET
//   alu_out   in   RET target
//   siic      in   exception request
//   rti       in   return from exception
//   halt_req  in   HALT instruction
//   pc        out  current fetch PC (registered)
//   pc_inc    out  pc + INC, combinational, wraps modulo 2^WIDTH
//   epc       out  saved exception return PC (registered)
//   redirect  out  one-cycle pulse: pc was loaded non-sequentially
//   in_exc    out  high while in EXC
//   halted    out  high while in HALT
module pc_sequencer #(
  parameter int unsigned       WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(2),
  parameter int unsigned       INC       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             jmp,
  input  logic [WIDTH-1:0] brj_dest,
  input  logic             ret,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             siic,
  input  logic             rti,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc,
  output logic [WIDTH-1:0] epc,
  output logic             redirect,
  output logic             in_exc,
  output logic             halted
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] epc_reg, epc_next;
  logic             redirect_reg, redirect_next;

  // Truncation to WIDTH bits gives the modulo 2^WIDTH wrap for free.
  assign pc_inc = pc_reg + WIDTH'(INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      pc_reg       <= RESET_VEC;
      epc_reg      <= '0;
      redirect_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      epc_reg      <= epc_next;
      redirect_reg <= redirect_next;
    end
  end

  // Next-state / next-PC selection. The if-chain order is the priority:
  // siic, rti, ret, jmp/br_taken, halt_req, stall, increment.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    epc_next      = epc_reg;
    redirect_next = 1'b0;
    case (state_reg)
      ST_RUN, ST_EXC: begin
        if (siic) begin
          if (state_reg == ST_RUN) begin
            pc_next       = EXC_VEC;
            epc_next      = pc_inc;
            state_next    = ST_EXC;
            redirect_next = 1'b1;
          end else begin
            // Double fault: freeze everything and stop.
            state_next = ST_HALT;
          end
        end else if (rti && state_reg == ST_EXC) begin
          pc_next       = epc_reg;
          state_next    = ST_RUN;
          redirect_next = 1'b1;
        end else if (rti) begin
          // rti outside a handler is an ordinary sequential instruction;
          // it still outranks ret/jmp/br_taken, so those are not taken.
          if (halt_req) begin
            state_next = ST_HALT;
          end else if (!stall) begin
            pc_next = pc_inc;
          end
        end else if (ret) begin
          pc_next       = alu_out;
          redirect_next = 1'b1;
        end else if (jmp || br_taken) begin
          pc_next       = brj_dest;
          redirect_next = 1'b1;
        end else if (halt_req) begin
          state_next = ST_HALT;
        end else if (!stall) begin
          pc_next = pc_inc;
        end
      end
      default: begin
        // HALT (and any unreachable encoding): only rst leaves this state.
        state_next = ST_HALT;
      end
    endcase
  end

  assign pc       = pc_reg;
  assign epc      = epc_reg;
  assign redirect = redirect_reg;
  assign in_exc   = (state_reg == ST_EXC);
  assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Purpose: self-checking bench for pc_sequencer with default parameters.
//   A behavioural model (integer PC arithmetic, a mode number) is updated on
//   every rising edge; a compare process checks all DUT outputs against it on
//   every falling edge. Directed vectors additionally check hand-computed
//   literal values one time unit after the edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic        jmp;
  logic [15:0] brj_dest;
  logic        ret;
  logic [15:0] alu_out;
  logic        siic;
  logic        rti;
  logic        halt_req;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [15:0] epc;
  logic        redirect;
  logic        in_exc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .br_taken (br_taken),
    .jmp      (jmp),
    .brj_dest (brj_dest),
    .ret      (ret),
    .alu_out  (alu_out),
    .siic     (siic),
    .rti      (rti),
    .halt_req (halt_req),
    .pc       (pc),
    .pc_inc   (pc_inc),
    .epc      (epc),
    .redirect (redirect),
    .in_exc   (in_exc),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model. mode: 0 = running, 1 = in exception handler, 2 = halted.
  int m_pc;
  int m_epc;
  int m_mode;
  bit m_redir;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0;
      m_epc = 0;
      m_mode = 0;
      m_redir = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      m_redir = 1'b0;
      if (m_mode != 2) begin
        if (siic) begin
          if (m_mode == 0) begin
            m_epc = (m_pc + 2) % 65536;
            m_pc = 2;
            m_mode = 1;
            m_redir = 1'b1;
          end else begin
            m_mode = 2;
          end
        end else if (rti && m_mode == 1) begin
          m_pc = m_epc;
          m_mode = 0;
          m_redir = 1'b1;
        end else if (!rti && ret) begin
          m_pc = int'(alu_out);
          m_redir = 1'b1;
        end else if (!rti && (jmp || br_taken)) begin
          m_pc = int'(brj_dest);
          m_redir = 1'b1;
        end else if (halt_req) begin
          m_mode = 2;
        end else if (!stall) begin
          m_pc = (m_pc + 2) % 65536;
        end
      end
    end
  end

  task automatic cmp(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("model.pc",       int'(pc),       m_pc);
      cmp("model.pc_inc",   int'(pc_inc),   (m_pc + 2) % 65536);
      cmp("model.epc",      int'(epc),      m_epc);
      cmp("model.redirect", int'(redirect), int'(m_redir));
      cmp("model.in_exc",   int'(in_exc),   int'(m_mode == 1));
      cmp("model.halted",   int'(halted),   int'(m_mode == 2));
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit r, input bit s, input bit br, input bit j,
                     input bit rt, input bit si, input bit ri, input bit h,
                     input logic [15:0] dest, input logic [15:0] alu);
    rst = r; stall = s; br_taken = br; jmp = j; ret = rt;
    siic = si; rti = ri; halt_req = h; brj_dest = dest; alu_out = alu;
    @(posedge clk);
    #1;
    $display("cycle t=%0t rst=%0b stall=%0b br=%0b jmp=%0b ret=%0b siic=%0b rti=%0b halt=%0b -> pc=%h epc=%h redir=%0b exc=%0b halted=%0b",
             $time, r, s, br, j, rt, si, ri, h, pc, epc, redirect, in_exc, halted);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; ret = 1'b0;
    siic = 1'b0; rti = 1'b0; halt_req = 1'b0; brj_dest = '0; alu_out = '0;

    // Reset, then three idle clocks.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    cmp("reset.pc", int'(pc), 16'h0000);
    cmp("reset.epc", int'(epc), 16'h0000);
    cmp("reset.flags", int'({redirect, in_exc, halted}), 0);
    idle(); cmp("seq.pc1", int'(pc), 16'h0002); cmp("seq.redir1", int'(redirect), 0);
    idle(); cmp("seq.pc2", int'(pc), 16'h0004);
    idle(); cmp("seq.pc3", int'(pc), 16'h0006); cmp("seq.redir3", int'(redirect), 0);

    // Branch overrides stall, then stall alone holds.
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 16'h0010, 16'h0000);
    cmp("jmp.pc", int'(pc), 16'h0010); cmp("jmp.redir", int'(redirect), 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 16'h3232, 16'h0000);
    cmp("br_stall.pc", int'(pc), 16'h3232); cmp("br_stall.redir", int'(redirect), 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    cmp("stall.pc", int'(pc), 16'h3232); cmp("stall.redir", int'(redirect), 0);

    // Exception entry and return.
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 16'h0040, 16'h0000);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    cmp("siic.pc", int'(pc), 16'h0002); cmp("siic.epc", int'(epc), 16'h0042);
    cmp("siic.in_exc", int'(in_exc), 1); cmp("siic.redir", int'(redirect), 1);
    idle(); idle();
    cmp("exc_seq.pc", int'(pc), 16'h0006);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    cmp("rti.pc", int'(pc), 16'h0042); cmp("rti.in_exc", int'(in_exc), 0);
    cmp("rti.redir", int'(redirect), 1);

    // rti while running is sequential and respects stall.
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    cmp("rti_run_stall.pc", int'(pc), 16'h0042); cmp("rti_run_stall.redir", int'(redirect), 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    cmp("rti_run.pc", int'(pc), 16'h0044);

    // Double fault, halted ignores redirects, reset recovers.
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    cmp("siic2.epc", int'(epc), 16'h0046);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    cmp("dfault.halted", int'(halted), 1); cmp("dfault.pc", int'(pc), 16'h0002);
    cmp("dfault.epc", int'(epc), 16'h0046);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 1, 0, 1, 0, 16'h1234, 16'h5678);
      cmp("halt_hold.pc", int'(pc), 16'h0002);
      cmp("halt_hold.redir", int'(redirect), 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    cmp("halt_rst.pc", int'(pc), 16'h0000); cmp("halt_rst.halted", int'(halted), 0);
    cmp("halt_rst.epc", int'(epc), 16'h0000);
    idle(); cmp("post_rst.pc", int'(pc), 16'h0002);

    // Wrap-around and ret priority over jmp.
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFE, 16'h0000);
    cmp("wrap.pc_inc", int'(pc_inc), 16'h0000);
    idle(); cmp("wrap.pc", int'(pc), 16'h0000);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 16'h7171, 16'hF4F4);
    cmp("ret_wins.pc", int'(pc), 16'hF4F4); cmp("ret_wins.redir", int'(redirect), 1);

    // halt_req loses to a redirect, then halts on its own.
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 16'h0A0A, 16'h0000);
    cmp("halt_jmp.pc", int'(pc), 16'h0A0A); cmp("halt_jmp.halted", int'(halted), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    cmp("halt.halted", int'(halted), 1); cmp("halt.pc", int'(pc), 16'h0A0A);
    cmp("halt.redir", int'(redirect), 0);
    idle(); cmp("halt_idle.pc", int'(pc), 16'h0A0A);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    cmp("halt_siic.in_exc", int'(in_exc), 0); cmp("halt_siic.pc", int'(pc), 16'h0A0A);

    // Reset from mid-handler.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000);
    cmp("exc2.in_exc", int'(in_exc), 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 16'h5555, 16'h0000);
    cmp("exc_rst.pc", int'(pc), 16'h0000); cmp("exc_rst.in_exc", int'(in_exc), 0);
    idle(); cmp("exc_rst_seq.pc", int'(pc), 16'h0002);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
